// File: rtl/uart_frame_packer_pkg.sv
// Shared types and helpers for the UART frame packer.
package uart_frame_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_SEND,
    ST_GAP
  } state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Clock cycles covering 11 bit times, so the last byte leaves the line before the next request
  function automatic int unsigned gap_cycles(input int unsigned clk_mhz, input int unsigned baud);
    return ((clk_mhz * 32'd1_000_000) / baud) * 32'd11;
  endfunction

endpackage

// File: rtl/uart_frame_packer_sync.sv
// Synchronous FIFO with extra-bit pointers and a registered occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO is still accepted when the head leaves in the same cycle
  assign rd_en     = pop & ~empty_c;
  assign wr_en     = push & (~full_c | rd_en);
  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data_c = mem[rd_ptr[AW-1:0]];

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_packer.sv
// Buffers words, wraps them in {header, seq, payload, csum} frames and hands them to the UART transmitter.
module uart_frame_packer
  import uart_frame_packer_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  HEADER     = DEFAULT_HEADER
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [WORD_W-1:0]             word_i,
  input  logic                          word_valid_i,
  input  logic                          tx_busy_i,
  input  logic                          clr_ovf_i,
  output logic                          send_en_o,
  output logic [8*(WORD_W/8+3)-1:0]     frame_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned PAY_B      = WORD_W / 8;
  localparam int unsigned BYTE_NUM   = PAY_B + 3;
  localparam int unsigned FRAME_W    = 8 * BYTE_NUM;
  localparam int unsigned GAP_CYCLES = gap_cycles(CLK_FREQ, BAUD_RATE);
  localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);

  state_e            state;
  state_e            state_next;
  logic              pop_c;
  logic              drop_c;
  logic              gap_done_c;
  logic [7:0]        csum_c;
  logic [7:0]        seq;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WORD_W-1:0] head_c;
  logic              full_c;
  logic              empty_c;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push      (word_valid_i),
    .pop       (pop_c),
    .wr_data   (word_i),
    .rd_data_c (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .level     (fifo_level_o)
  );

  assign drop_c     = word_valid_i & full_c & ~pop_c;
  assign gap_done_c = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  // Checksum over the sequence byte and the payload bytes of the FIFO head
  always_comb begin
    csum_c = seq;
    for (int unsigned i = 0; i < PAY_B; i++) begin
      csum_c = csum_c + head_c[8*i +: 8];
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; the head is popped during the single LOAD cycle
  always_comb begin
    state_next = state;
    pop_c      = 1'b0;
    unique case (state)
      ST_IDLE: if (!empty_c && !tx_busy_i) state_next = ST_LOAD;
      ST_LOAD: begin
        pop_c      = 1'b1;
        state_next = ST_REQ;
      end
      ST_REQ:  if (tx_busy_i)  state_next = ST_SEND;
      ST_SEND: if (!tx_busy_i) state_next = ST_GAP;
      ST_GAP:  if (gap_done_c) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame register, sequence counter, send request, gap timer and sticky overflow
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      send_en_o  <= 1'b0;
      frame_o    <= '0;
      overflow_o <= 1'b0;
      seq        <= '0;
      gap_cnt    <= '0;
    end else begin
      send_en_o <= (state_next == ST_REQ);
      if (state == ST_LOAD) begin
        frame_o <= FRAME_W'({HEADER, seq, head_c, csum_c});
        seq     <= seq + 8'd1;
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (drop_c)         overflow_o <= 1'b1;
      else if (clr_ovf_i) overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer with a small transmitter model driving tx_busy.
module tb_uart_frame_packer;

  localparam int GAP_CYCLES = 11;  // 1 MHz clock, 1 Mbaud -> 1 * 11
  localparam int BUSY_LEN   = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] word;
  logic        word_valid;
  logic        busy_force;
  logic        clr_ovf;
  logic        send_en;
  logic [39:0] frame;
  logic        overflow;
  logic [3:0]  level;
  logic        busy_m;
  wire         tx_busy = busy_m | busy_force;

  int total;
  int bad;
  int rx_base;
  int gap_base;

  // transmitter model state
  logic [39:0] rx_frame [0:1023];
  int          gap_val  [0:1023];
  int          rx_cnt;
  int          gap_cnt;

  uart_frame_packer #(
    .CLK_FREQ   (1),
    .BAUD_RATE  (1000000),
    .WORD_W     (16),
    .FIFO_DEPTH (8),
    .HEADER     (8'hA5)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .word_i       (word),
    .word_valid_i (word_valid),
    .tx_busy_i    (tx_busy),
    .clr_ovf_i    (clr_ovf),
    .send_en_o    (send_en),
    .frame_o      (frame),
    .overflow_o   (overflow),
    .fifo_level_o (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter: 2-stage enable detect, latches frame, busy for BUSY_LEN cycles; also logs inter-frame gaps
  initial begin
    int  hold;
    int  busy_cnt;
    int  since_fall;
    bit  fall_seen;
    bit  sen_prev;
    busy_m = 1'b0; rx_cnt = 0; gap_cnt = 0;
    hold = 0; busy_cnt = 0; since_fall = 0; fall_seen = 1'b0; sen_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_m = 1'b0; busy_cnt = 0; hold = 0; fall_seen = 1'b0; sen_prev = 1'b0; since_fall = 0;
      end else begin
        if (send_en && !sen_prev && fall_seen) begin
          if (gap_cnt < 1024) gap_val[gap_cnt] = since_fall;
          gap_cnt++;
          fall_seen = 1'b0;
        end
        since_fall++;
        if (busy_m) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            busy_m = 1'b0; since_fall = 0; fall_seen = 1'b1;
          end
        end else begin
          hold = send_en ? hold + 1 : 0;
          if (hold == 2) begin
            if (rx_cnt < 1024) rx_frame[rx_cnt] = frame;
            rx_cnt++;
            busy_m = 1'b1; busy_cnt = BUSY_LEN; hold = 0;
          end
        end
        sen_prev = send_en;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] exp_frame(input logic [7:0] s, input logic [15:0] w);
    logic [7:0] c;
    c = 8'(s + w[15:8] + w[7:0]);
    return {8'hA5, s, w, c};
  endfunction

  function automatic logic [15:0] t4_word(input int k);
    return 16'(k * 291 + 3855);
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; word_valid = 1'b0; clr_ovf = 1'b0; busy_force = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic push1(input logic [15:0] w);
    word = w; word_valid = 1'b1;
    tick;
    word_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while ((rx_cnt - rx_base) < n && k < budget) begin
      tick;
      k++;
    end
    chk("frames_rx", 64'(rx_cnt - rx_base), 64'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pushed;
    logic [39:0] f;
    total = 0; bad = 0;
    rst_n = 1'b0; word = '0; word_valid = 1'b0; busy_force = 1'b0; clr_ovf = 1'b0;

    // Test 1: reset values, single frame, latency and handshake
    do_reset;
    chk("rst_send_en", 64'(send_en), 64'(0));
    chk("rst_frame", 64'(frame), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    rx_base = rx_cnt;
    push1(16'h1234);
    chk("t1_lat_push_sen", 64'(send_en), 64'(0));
    chk("t1_lat_push_level", 64'(level), 64'(1));
    tick;
    chk("t1_lat_load_sen", 64'(send_en), 64'(0));
    tick;
    chk("t1_lat_req_sen", 64'(send_en), 64'(1));
    chk("t1_lat_req_level", 64'(level), 64'(0));
    n = 0;
    while (!tx_busy && n < 20) begin tick; n++; end
    chk("t1_busy_seen", 64'(tx_busy), 64'(1));
    chk("t1_sen_at_busy", 64'(send_en), 64'(1));
    tick;
    chk("t1_sen_drop", 64'(send_en), 64'(0));
    wait_frames(1, 100);
    chk("t1_frame", 64'(rx_frame[rx_base]), 64'(40'hA5_00_1234_46));

    // Test 2: burst of 8, in-order frames, gap enforcement
    do_reset;
    rx_base = rx_cnt; gap_base = gap_cnt;
    busy_force = 1'b1;
    tick;
    for (int k = 0; k < 8; k++) push1(16'(k + 1));
    chk("t2_peak_level", 64'(level), 64'(8));
    chk("t2_overflow", 64'(overflow), 64'(0));
    busy_force = 1'b0;
    wait_frames(8, 600);
    for (int k = 0; k < 8; k++) begin
      f = exp_frame(8'(k), 16'(k + 1));
      chk("t2_frame", 64'(rx_frame[rx_base + k]), 64'(f));
    end
    chk("t2_frame3_const", 64'(rx_frame[rx_base + 3]), 64'(40'hA5_03_0004_07));
    chk("t2_gap_count", 64'(gap_cnt - gap_base), 64'(7));
    for (int k = 0; k < 7; k++)
      chk("t2_gap_len", 64'(gap_val[gap_base + k]), 64'(GAP_CYCLES + 2));

    // Test 3: overflow, clear, clear-vs-drop priority
    do_reset;
    rx_base = rx_cnt;
    busy_force = 1'b1;
    tick;
    for (int k = 0; k < 8; k++) push1(16'hA000 + 16'(k));
    chk("t3_level_full", 64'(level), 64'(8));
    chk("t3_ovf_before", 64'(overflow), 64'(0));
    push1(16'hDEAD);
    chk("t3_ovf_drop", 64'(overflow), 64'(1));
    chk("t3_level_after_drop", 64'(level), 64'(8));
    clr_ovf = 1'b1; tick; clr_ovf = 1'b0;
    chk("t3_ovf_clr", 64'(overflow), 64'(0));
    clr_ovf = 1'b1; word = 16'hBAD0; word_valid = 1'b1;
    tick;
    clr_ovf = 1'b0; word_valid = 1'b0;
    chk("t3_ovf_set_wins", 64'(overflow), 64'(1));
    clr_ovf = 1'b1; tick; clr_ovf = 1'b0;
    chk("t3_ovf_clr2", 64'(overflow), 64'(0));

    // Test 5: push during LOAD at full level
    busy_force = 1'b0;
    tick;
    word = 16'h5555; word_valid = 1'b1;
    tick;
    word_valid = 1'b0;
    chk("t5_level", 64'(level), 64'(8));
    chk("t5_overflow", 64'(overflow), 64'(0));
    wait_frames(9, 800);
    for (int k = 0; k < 8; k++) begin
      f = exp_frame(8'(k), 16'hA000 + 16'(k));
      chk("t35_frame", 64'(rx_frame[rx_base + k]), 64'(f));
    end
    chk("t5_frame_last", 64'(rx_frame[rx_base + 8]), 64'(40'hA5_08_5555_B2));

    // Test 4: 257 frames, sequence wrap, checksum on every frame
    do_reset;
    rx_base = rx_cnt;
    pushed = 0; n = 0;
    while (pushed < 257 && n < 20000) begin
      if (level < 4'd8) begin
        word = t4_word(pushed); word_valid = 1'b1; pushed++;
      end else begin
        word_valid = 1'b0;
      end
      tick;
      n++;
    end
    word_valid = 1'b0;
    chk("t4_all_pushed", 64'(pushed), 64'(257));
    wait_frames(257, 10000);
    for (int k = 0; k < 257; k++) begin
      f = exp_frame(8'(k), t4_word(k));
      chk("t4_frame", 64'(rx_frame[rx_base + k]), 64'(f));
    end
    f = rx_frame[rx_base + 255];
    chk("t4_seq_255", 64'(f[31:24]), 64'(8'hFF));
    f = rx_frame[rx_base + 256];
    chk("t4_seq_wrap", 64'(f[31:24]), 64'(8'h00));
    chk("t4_overflow", 64'(overflow), 64'(0));

    // Test 6: reset during REQ and during SEND
    do_reset;
    push1(16'h1111);
    n = 0;
    while (!send_en && n < 20) begin tick; n++; end
    chk("t6_req_reached", 64'(send_en), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_req_rst_sen", 64'(send_en), 64'(0));
    chk("t6_req_rst_frame", 64'(frame), 64'(0));
    chk("t6_req_rst_level", 64'(level), 64'(0));
    tick;
    rst_n = 1'b1;
    tick;
    push1(16'h2222);
    n = 0;
    while (!tx_busy && n < 20) begin tick; n++; end
    chk("t6_busy_reached", 64'(tx_busy), 64'(1));
    tick;
    chk("t6_in_send", 64'(send_en), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("t6_send_rst_frame", 64'(frame), 64'(0));
    chk("t6_send_rst_ovf", 64'(overflow), 64'(0));
    chk("t6_send_rst_level", 64'(level), 64'(0));
    tick;
    rst_n = 1'b1;
    tick;
    rx_base = rx_cnt;
    push1(16'hBEEF);
    wait_frames(1, 100);
    chk("t6_frame_seq0", 64'(rx_frame[rx_base]), 64'(40'hA5_00_BEEF_AD));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
